// File: rtl/nbbpu_fetch.sv
// nbbpu_fetch: instruction fetch stage feeding the NBBPU core from an 8-bit program ROM
//   Each 16-bit instruction is read as two little-endian byte transfers, then held until the PC word changes.
//   Ports:
//     i_clk          system clock, rising edge
//     i_rst_n        asynchronous active-low reset
//     i_pc           program counter from the core; bit 0 ignored
//     o_instruction  assembled instruction {hi_byte, lo_byte}
//     o_instr_valid  instruction corresponds to the current PC word
//     o_rom_req      ROM read request, held until acknowledged
//     o_rom_addr     ROM byte address, stable while o_rom_req=1
//     i_rom_ack      ROM accepts request; i_rom_data valid this cycle
//     i_rom_data     ROM read byte
//     o_bus_error    sticky ROM timeout fault, cleared only by reset
module nbbpu_fetch #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pc,
  output logic [15:0]       o_instruction,
  output logic              o_instr_valid,
  output logic              o_rom_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic              i_rom_ack,
  input  logic [7:0]        i_rom_data,
  output logic              o_bus_error
);
  // The counter only ever holds 0..TIMEOUT-1; the edge that would reach TIMEOUT leaves for ERROR.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_HOLD, S_ERR} state_t;
  state_t          r_state, w_next;
  logic [15:0]     r_fetch_pc;
  logic [7:0]      r_lo;
  logic [15:0]     r_instr;
  logic [CW-1:0]   r_cnt;
  logic            w_match, w_xfer, w_tout;
  assign w_match       = i_pc[15:1] == r_fetch_pc[15:1];
  assign o_rom_req     = (r_state == S_LO) || (r_state == S_HI);
  assign w_xfer        = o_rom_req && i_rom_ack;
  // An ack on the same edge always wins over the timeout.
  assign w_tout        = (TIMEOUT > 0) && o_rom_req && !i_rom_ack && (r_cnt == CW'(TIMEOUT - 1));
  assign o_rom_addr    = r_fetch_pc[ADDR_W-1:0] + ADDR_W'(r_state == S_HI);
  assign o_instr_valid = (r_state == S_HOLD) && w_match;
  assign o_bus_error   = r_state == S_ERR;
  assign o_instruction = r_instr;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_LO;
      S_LO:    w_next = w_tout ? S_ERR : w_xfer ? S_HI : S_LO;
      S_HI:    w_next = w_tout ? S_ERR : !w_xfer ? S_HI : w_match ? S_HOLD : S_LO;
      S_HOLD:  w_next = w_match ? S_HOLD : S_LO;
      default: w_next = S_ERR;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_lo       <= '0;
      r_instr    <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (!o_rom_req || w_xfer) ? '0 : r_cnt + CW'(1);
      // A stale high-byte transfer is discarded and the new PC word refetched from its low byte.
      if ((r_state == S_IDLE) || (r_state == S_HOLD && !w_match) || (r_state == S_HI && w_xfer && !w_match))
        r_fetch_pc <= i_pc & 16'hFFFE;
      if (r_state == S_LO && w_xfer)
        r_lo <= i_rom_data;
      if (r_state == S_HI && w_xfer && w_match)
        r_instr <= {i_rom_data, r_lo};
    end
  end
endmodule

// File: tb/tb_nbbpu_fetch.sv
// tb_nbbpu_fetch: scoreboard bench for nbbpu_fetch with an 8-bit address space and a 5-cycle timeout
module tb_nbbpu_fetch;
  localparam int AW = 8;
  localparam int TO = 5;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   pc = 16'h0000;
  logic [15:0]   instr;
  logic          valid, req, berr;
  logic          ack = 1'b0;
  logic [AW-1:0] addr;
  logic [7:0]    data = 8'h00;
  int            total = 0;
  int            bad = 0;
  logic [7:0]    mem [256];
  int            wait_cfg = 0;
  bit            ack_en = 1'b1;
  int            wc = 0;
  logic [15:0]   q_exp [$];
  logic [AW-1:0] q_xfer [$];

  nbbpu_fetch #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc(pc),
    .o_instruction(instr), .o_instr_valid(valid),
    .o_rom_req(req), .o_rom_addr(addr),
    .i_rom_ack(ack), .i_rom_data(data), .o_bus_error(berr)
  );

  always #5 clk = ~clk;

  // ROM model: acks after wait_cfg idle request cycles and logs each address it acknowledges.
  initial forever begin
    @(negedge clk);
    if (!req) begin
      wc = 0;
      ack = 1'b0;
    end else begin
      ack = ack_en && (wc >= wait_cfg);
      data = mem[addr];
      if (ack) begin
        q_xfer.push_back(addr);
        wc = 0;
      end else wc++;
    end
  end

  task automatic apply(input logic [15:0] p, input logic [15:0] e);
    pc = p;
    q_exp.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc = 16'h0000;
    repeat (2) @(negedge clk);
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", instr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", addr); end
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL reset_berr got=%b want=0", berr); end
  endtask

  task automatic test_zero_wait();
    int n;
    logic [15:0] e;
    wait_cfg = 0;
    q_xfer.delete();
    apply(16'h0000, 16'h1234);
    rst_n = 1'b1;
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3) begin bad++; $display("FAIL zw0_latency got=%0d want=3", n); end
    total++; if (instr !== e) begin bad++; $display("FAIL zw0_instr got=%h want=%h", instr, e); end
    total++; if (q_xfer.size() !== 2 || q_xfer[0] !== 8'h00 || q_xfer[1] !== 8'h01) begin
      bad++; $display("FAIL zw0_addrs n=%0d got=%h,%h want=00,01", q_xfer.size(), q_xfer[0], q_xfer[1]);
    end
    q_xfer.delete();
    apply(16'h0002, 16'h5678);
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL zw2_drop got=%b want=0", valid); end
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3) begin bad++; $display("FAIL zw2_latency got=%0d want=3", n); end
    total++; if (instr !== e) begin bad++; $display("FAIL zw2_instr got=%h want=%h", instr, e); end
    total++; if (q_xfer.size() !== 2 || q_xfer[0] !== 8'h02 || q_xfer[1] !== 8'h03) begin
      bad++; $display("FAIL zw2_addrs n=%0d got=%h,%h want=02,03", q_xfer.size(), q_xfer[0], q_xfer[1]);
    end
  endtask

  // Four wait cycles per byte; the ack lands on the 5th request cycle, exactly at the timeout limit.
  task automatic test_wait();
    logic [AW-1:0] ea;
    logic [15:0] e;
    wait_cfg = 4;
    apply(16'h0000, 16'h1234);
    for (int k = 1; k <= 10; k++) begin
      edge_step();
      ea = (k <= 5) ? 8'h00 : 8'h01;
      total++; if (req !== 1'b1 || addr !== ea || valid !== 1'b0 || berr !== 1'b0) begin
        bad++; $display("FAIL wait_edge%0d req=%b addr=%h valid=%b berr=%b want 1,%h,0,0", k, req, addr, valid, berr, ea);
      end
    end
    edge_step();
    e = q_exp.pop_front();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL wait_valid11 got=%b want=1", valid); end
    total++; if (instr !== e) begin bad++; $display("FAIL wait_instr got=%h want=%h", instr, e); end
  endtask

  task automatic test_addr_wrap();
    int n;
    logic [15:0] e;
    wait_cfg = 0;
    q_xfer.delete();
    apply(16'h01FE, 16'hBEEF);
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3 || instr !== e) begin bad++; $display("FAIL aw_1fe n=%0d instr=%h want 3,%h", n, instr, e); end
    total++; if (q_xfer.size() !== 2 || q_xfer[0] !== 8'hFE || q_xfer[1] !== 8'hFF) begin
      bad++; $display("FAIL aw_1fe_addrs n=%0d got=%h,%h want=fe,ff", q_xfer.size(), q_xfer[0], q_xfer[1]);
    end
    q_xfer.delete();
    apply(16'h00FF, 16'hBEEF);
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL aw_ff_drop got=%b want=0", valid); end
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3 || instr !== e) begin bad++; $display("FAIL aw_0ff n=%0d instr=%h want 3,%h", n, instr, e); end
    total++; if (q_xfer.size() !== 2 || q_xfer[0] !== 8'hFE || q_xfer[1] !== 8'hFF) begin
      bad++; $display("FAIL aw_0ff_addrs n=%0d got=%h,%h want=fe,ff", q_xfer.size(), q_xfer[0], q_xfer[1]);
    end
    pc = 16'h00FE;
    #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL aw_bit0_ignored got=%b want=1", valid); end
  endtask

  task automatic test_reset_hi();
    int n;
    logic [15:0] e;
    wait_cfg = 3;
    pc = 16'h0002;
    repeat (6) edge_step();
    total++; if (req !== 1'b1 || addr !== 8'h03) begin bad++; $display("FAIL rh_in_hi req=%b addr=%h want 1,03", req, addr); end
    rst_n = 1'b0;
    #1;
    total++; if (instr !== 16'h0000 || valid !== 1'b0 || req !== 1'b0 || addr !== 8'h00 || berr !== 1'b0) begin
      bad++; $display("FAIL rh_async instr=%h valid=%b req=%b addr=%h berr=%b want 0000,0,0,00,0", instr, valid, req, addr, berr);
    end
    wait_cfg = 0;
    apply(16'h0002, 16'h5678);
    @(negedge clk);
    q_xfer.delete();
    rst_n = 1'b1;
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3 || instr !== e) begin bad++; $display("FAIL rh_refetch n=%0d instr=%h want 3,%h", n, instr, e); end
    total++; if (q_xfer.size() !== 2 || q_xfer[0] !== 8'h02 || q_xfer[1] !== 8'h03) begin
      bad++; $display("FAIL rh_addrs n=%0d got=%h,%h want=02,03", q_xfer.size(), q_xfer[0], q_xfer[1]);
    end
  endtask

  task automatic test_midfetch();
    logic [15:0] e;
    wait_cfg = 2;
    rst_n = 1'b0;
    pc = 16'h0000;
    @(negedge clk);
    q_xfer.delete();
    rst_n = 1'b1;
    edge_step();
    total++; if (req !== 1'b1 || addr !== 8'h00) begin bad++; $display("FAIL mf_lo req=%b addr=%h want 1,00", req, addr); end
    apply(16'h0004, 16'h9ABC);
    for (int k = 2; k <= 12; k++) begin
      edge_step();
      total++; if (valid !== 1'b0 || instr !== 16'h0000) begin
        bad++; $display("FAIL mf_edge%0d valid=%b instr=%h want 0,0000", k, valid, instr);
      end
    end
    edge_step();
    e = q_exp.pop_front();
    total++; if (valid !== 1'b1 || instr !== e) begin bad++; $display("FAIL mf_done valid=%b instr=%h want 1,%h", valid, instr, e); end
    total++; if (q_xfer.size() !== 4 || q_xfer[0] !== 8'h00 || q_xfer[1] !== 8'h01 || q_xfer[2] !== 8'h04 || q_xfer[3] !== 8'h05) begin
      bad++; $display("FAIL mf_addrs n=%0d got=%h,%h,%h,%h want=00,01,04,05", q_xfer.size(), q_xfer[0], q_xfer[1], q_xfer[2], q_xfer[3]);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [15:0] e;
    ack_en = 1'b0;
    q_xfer.delete();
    pc = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      edge_step();
      if (k <= 5) begin
        total++; if (req !== 1'b1 || berr !== 1'b0) begin bad++; $display("FAIL to_wait%0d req=%b berr=%b want 1,0", k, req, berr); end
      end else begin
        total++; if (req !== 1'b0 || berr !== 1'b1 || valid !== 1'b0) begin
          bad++; $display("FAIL to_fault req=%b berr=%b valid=%b want 0,1,0", req, berr, valid);
        end
      end
    end
    ack_en = 1'b1;
    pc = 16'h0004;
    repeat (5) edge_step();
    total++; if (berr !== 1'b1 || req !== 1'b0 || valid !== 1'b0 || q_xfer.size() !== 0) begin
      bad++; $display("FAIL to_sticky berr=%b req=%b valid=%b xfers=%0d want 1,0,0,0", berr, req, valid, q_xfer.size());
    end
    rst_n = 1'b0;
    #1;
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL to_reset_clear got=%b want=0", berr); end
    wait_cfg = 0;
    apply(16'h0004, 16'h9ABC);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    e = q_exp.pop_front();
    total++; if (n !== 3 || instr !== e) begin bad++; $display("FAIL to_recover n=%0d instr=%h want 3,%h", n, instr, e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
    mem[4] = 8'hBC; mem[5] = 8'h9A; mem[8'hFE] = 8'hEF; mem[8'hFF] = 8'hBE;
    test_reset();
    test_zero_wait();
    test_wait();
    test_addr_wrap();
    test_reset_hi();
    test_midfetch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
